// File: rtl/fetch_queue_if.sv
// Fetch-queue bundle: upstream fetch slot, instruction memory port and decode-side head.
// master drives the fetch/decode requests; slave is the queue itself.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   IP;
  logic          enq_en;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_data;
  logic          flush;
  logic          full;
  logic [CW-1:0] count;
  logic          dq_valid;
  logic          dq_ready;
  logic [31:0]   dq_inst;
  logic [31:0]   dq_pc;
  logic [31:0]   dq_pc4;
  logic [6:0]    OP;

  modport master (
    output IP, enq_en, imem_data, flush, dq_ready,
    input  imem_addr, full, count, dq_valid, dq_inst, dq_pc, dq_pc4, OP
  );

  modport slave (
    input  IP, enq_en, imem_data, flush, dq_ready,
    output imem_addr, full, count, dq_valid, dq_inst, dq_pc, dq_pc4, OP
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch FIFO between PC and decode: captures {imem_data, IP} per fetch slot,
// presents the oldest entry through valid/ready, flushes everything on a taken redirect.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  fetch_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [31:0]   NOP_INST  = 32'h0000_0013;

  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic full;
  logic dq_valid;
  logic enq;
  logic deq;

  // full/valid come only from registered occupancy, never from enq_en/dq_ready
  assign full     = (count_reg == DEPTH_CNT);
  assign dq_valid = (count_reg != '0);
  assign enq      = bus.enq_en & ~full & ~bus.flush & ~RESET;
  assign deq      = dq_valid & bus.dq_ready & ~bus.flush & ~RESET;

  always_ff @(posedge CLK) begin
    if (RESET || bus.flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (deq) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (enq && !deq)      count_reg <= count_reg + 1'b1;
      else if (deq && !enq) count_reg <= count_reg - 1'b1;
    end
  end

  // Storage needs no reset: contents are only visible through a valid head.
  always_ff @(posedge CLK) begin
    if (enq) begin
      inst_mem[wr_ptr_reg] <= bus.imem_data;
      pc_mem[wr_ptr_reg]   <= bus.IP;
    end
  end

  logic [31:0] head_inst;
  logic [31:0] head_pc;

  assign head_inst = dq_valid ? inst_mem[rd_ptr_reg] : NOP_INST;
  assign head_pc   = dq_valid ? pc_mem[rd_ptr_reg]   : 32'h0;

  assign bus.imem_addr = bus.IP;
  assign bus.full      = full;
  assign bus.count     = count_reg;
  assign bus.dq_valid  = dq_valid;
  assign bus.dq_inst   = head_inst;
  assign bus.dq_pc     = head_pc;
  assign bus.dq_pc4    = head_pc + 32'd4;
  assign bus.OP        = head_inst[6:0];
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset defaults, fill/overflow, enq+deq, streaming, flush, wrap.
module tb_fetch_queue;
  logic CLK = 1'b0;
  logic RESET;
  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  fetch_queue_if #(.DEPTH(4)) bus ();

  fetch_queue #(.DEPTH(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end else begin
      $display("ok   %s: %08h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".count"}, 32'(bus.count), 32'd0);
    check({tag, ".valid"}, 32'(bus.dq_valid), 32'd0);
    check({tag, ".inst"},  bus.dq_inst, 32'h0000_0013);
    check({tag, ".pc"},    bus.dq_pc, 32'h0);
    check({tag, ".pc4"},   bus.dq_pc4, 32'h4);
    check({tag, ".op"},    32'(bus.OP), 32'h13);
  endtask

  logic [31:0] fill_inst [4] = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'hFE00_08E3};

  initial begin
    RESET = 1'b1;
    bus.IP = 32'h0; bus.enq_en = 1'b0; bus.imem_data = 32'h0;
    bus.flush = 1'b0; bus.dq_ready = 1'b0;
    step(); step();
    RESET = 1'b0;
    step(); step(); step();
    check_empty("reset");
    check("reset.full", 32'(bus.full), 32'd0);
    bus.IP = 32'h0000_1234;
    #1;
    check("imem_addr", bus.imem_addr, 32'h0000_1234);

    // Fill to full with decode stalled
    for (int i = 0; i < 4; i++) begin
      bus.IP = 32'(i * 4); bus.imem_data = fill_inst[i]; bus.enq_en = 1'b1;
      step();
    end
    check("fill.count", 32'(bus.count), 32'd4);
    check("fill.full",  32'(bus.full), 32'd1);
    bus.IP = 32'h10; bus.imem_data = 32'hDEAD_BEEF;
    step();
    check("ovf.count", 32'(bus.count), 32'd4);
    check("ovf.pc",    bus.dq_pc, 32'h0);
    check("ovf.pc4",   bus.dq_pc4, 32'h4);
    check("ovf.inst",  bus.dq_inst, 32'h0050_0093);

    // From full: enq_en ignored, only dequeue
    bus.dq_ready = 1'b1;
    step();
    check("fdeq.count", 32'(bus.count), 32'd3);
    check("fdeq.full",  32'(bus.full), 32'd0);
    check("fdeq.pc",    bus.dq_pc, 32'h4);
    check("fdeq.inst",  bus.dq_inst, 32'h00A0_0113);
    bus.imem_data = 32'h1111_1111;
    step();
    check("both.count", 32'(bus.count), 32'd3);
    check("both.pc",    bus.dq_pc, 32'h8);
    check("both.inst",  bus.dq_inst, 32'h0020_81B3);

    bus.flush = 1'b1; bus.enq_en = 1'b0; bus.dq_ready = 1'b0;
    step();
    bus.flush = 1'b0;
    check_empty("flush1");

    // Streaming: each entry becomes head one edge after its enqueue
    bus.dq_ready = 1'b1; bus.enq_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.IP = 32'(i * 4); bus.imem_data = 32'h0000_1000 + 32'(i);
      step();
      check($sformatf("strm%0d.valid", i), 32'(bus.dq_valid), 32'd1);
      check($sformatf("strm%0d.pc", i),    bus.dq_pc, 32'(i * 4));
      check($sformatf("strm%0d.inst", i),  bus.dq_inst, 32'h0000_1000 + 32'(i));
      check($sformatf("strm%0d.count", i), 32'(bus.count), 32'd1);
    end
    bus.enq_en = 1'b0;
    step();
    check_empty("drain");

    // Queue 3, then flush with enq_en and dq_ready both high
    bus.dq_ready = 1'b0; bus.enq_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.IP = 32'h40 + 32'(i * 4); bus.imem_data = 32'h0000_2000 + 32'(i);
      step();
    end
    check("q3.count", 32'(bus.count), 32'd3);
    check("q3.pc",    bus.dq_pc, 32'h40);
    bus.IP = 32'h4C; bus.imem_data = 32'h0000_2003;
    bus.flush = 1'b1; bus.dq_ready = 1'b1;
    step();
    bus.flush = 1'b0; bus.enq_en = 1'b0; bus.dq_ready = 1'b0;
    check_empty("flush2");

    bus.IP = 32'h80; bus.imem_data = 32'h0000_006F; bus.enq_en = 1'b1;
    step();
    bus.enq_en = 1'b0;
    check("post.count", 32'(bus.count), 32'd1);
    check("post.pc",    bus.dq_pc, 32'h80);
    check("post.pc4",   bus.dq_pc4, 32'h84);
    check("post.op",    32'(bus.OP), 32'h6F);
    step();
    check("stall.pc",   bus.dq_pc, 32'h80);

    // Wrap of pc+4 at the top of the address space
    bus.IP = 32'hFFFF_FFFC; bus.imem_data = 32'hFE00_08E3;
    bus.enq_en = 1'b1; bus.dq_ready = 1'b1;
    step();
    bus.enq_en = 1'b0; bus.dq_ready = 1'b0;
    check("wrap.count", 32'(bus.count), 32'd1);
    check("wrap.pc",    bus.dq_pc, 32'hFFFF_FFFC);
    check("wrap.pc4",   bus.dq_pc4, 32'h0);
    check("wrap.op",    32'(bus.OP), 32'h63);

    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check_empty("rst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
